// File: rtl/ps2_key_decoder_if.sv
// Bus between the PS/2 key decoder and its neighbours: the receiver history
// register going in, the key-event stream and status flags coming out.
interface ps2_key_decoder_if;
  logic [15:0] code;
  logic        ev_ready;
  logic        ev_valid;
  logic [7:0]  ev_key;
  logic        ev_ext;
  logic        ev_break;
  logic [7:0]  ev_ascii;
  logic        shift_held;
  logic        overflow;

  modport master (
    output code, ev_ready,
    input  ev_valid, ev_key, ev_ext, ev_break, ev_ascii, shift_held, overflow
  );

  modport slave (
    input  code, ev_ready,
    output ev_valid, ev_key, ev_ext, ev_break, ev_ascii, shift_held, overflow
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Turns the Set-2 scan-code byte stream into make/break key events with ASCII
// translation, queued in a small FIFO with a valid/ready handshake.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ps2_key_decoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t      state_q, state_d;
  logic [15:0] prevCode_q;
  logic [1:0]  shift_q, shift_d;
  logic        overflow_q;
  logic [AW:0] wrPtr_q, rdPtr_q;
  logic [17:0] mem [FIFO_DEPTH];

  logic        newByte, isIgnored;
  logic [7:0]  rxByte, emitAscii;
  logic        emit, emitExt, emitBrk;
  logic        full, empty, push, pop;
  logic [17:0] head;

  function automatic logic [7:0] asciiOf(input logic [7:0] key, input logic shift);
    logic [7:0] ch;
    logic       letter;
    ch     = 8'h00;
    letter = 1'b1;
    case (key)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      if (shift) ch = ch - 8'h20;
    end else begin
      case (key)
        8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;
        8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;
        8'h3E: ch = 8'h38;  8'h46: ch = 8'h39;
        8'h29: ch = 8'h20;  8'h5A: ch = 8'h0D;  8'h66: ch = 8'h08;
        default: ch = 8'h00;
      endcase
    end
    return ch;
  endfunction

  // A byte is new only when the history register moved since last cycle.
  always_comb begin
    rxByte    = bus.code[15:8];
    newByte   = (bus.code != prevCode_q);
    isIgnored = rxByte inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  end

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    emitExt = 1'b0;
    emitBrk = 1'b0;
    if (newByte) begin
      case (state_q)
        IDLE: begin
          if (rxByte == 8'hE0)      state_d = EXT;
          else if (rxByte == 8'hF0) state_d = BRK;
          else if (!isIgnored)      emit = 1'b1;
        end
        EXT: begin
          if (rxByte == 8'hF0)      state_d = EXT_BRK;
          else if (rxByte == 8'hE0) state_d = EXT;
          else begin
            state_d = IDLE;
            emit    = !isIgnored;
            emitExt = 1'b1;
          end
        end
        BRK: begin
          if (rxByte == 8'hE0)      state_d = EXT;
          else if (rxByte == 8'hF0) state_d = BRK;
          else begin
            state_d = IDLE;
            emit    = 1'b1;
            emitBrk = 1'b1;
          end
        end
        EXT_BRK: begin
          if (rxByte != 8'hE0 && rxByte != 8'hF0) begin
            state_d = IDLE;
            emit    = 1'b1;
            emitExt = 1'b1;
            emitBrk = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ASCII uses the shift state from before this event; shift bits follow the event.
  always_comb begin
    emitAscii = emitExt ? 8'h00 : asciiOf(rxByte, |shift_q);
    shift_d   = shift_q;
    if (emit && !emitExt) begin
      if (rxByte == 8'h12) shift_d[0] = !emitBrk;
      if (rxByte == 8'h59) shift_d[1] = !emitBrk;
    end
  end

  always_comb begin
    empty = (wrPtr_q == rdPtr_q);
    full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    pop   = !empty && bus.ev_ready;
    push  = emit && (!full || pop);
    head  = empty ? 18'h0 : mem[rdPtr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q[AW-1:0]] <= {emitExt, emitBrk, rxByte, emitAscii};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prevCode_q <= 16'h0000;
      shift_q    <= 2'b00;
      overflow_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      state_q    <= state_d;
      prevCode_q <= bus.code;
      shift_q    <= shift_d;
      if (emit && full && !pop) overflow_q <= 1'b1;
      if (push) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (pop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  assign bus.ev_valid   = !empty;
  assign bus.ev_ext     = head[17];
  assign bus.ev_break   = head[16];
  assign bus.ev_key     = head[15:8];
  assign bus.ev_ascii   = head[7:0];
  assign bus.shift_held = |shift_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the 16-bit scan-code history register produced by the PS/2 receiver and turns the Set-2 byte stream into discrete key events. Each event carries make/break, extended-prefix, scan code and translated ASCII. Events are queued in a small FIFO with a valid/ready handshake toward the CPU-side I/O logic. The block also tracks the Shift key state for upper-case translation.

## Interface
- FIFO_DEPTH, 4, event queue depth; must be a power of two, at least 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- code  in  16  receiver history register; code[15:8] is the newest byte and code[7:0] the previous byte.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ev_valid  out  1  FIFO non-empty; head event is presented.
- ev_key  out  8  scan code of head event.
- ev_ext  out  1  head event was E0-prefixed.
- ev_break  out  1  head event is a key release.
- ev_ascii  out  8  ASCII of head event; 0x00 if the key is unmapped.
- shift_held  out  1  left Shift (0x12) or right Shift (0x59) is currently down.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- **Byte detection:**
  - Register prev_code (reset 0x0000).
  - A new byte is present in a cycle where code != prev_code; the byte is code[15:8].
  - prev_code <= code every cycle.
  - Identical repeated pairs (typematic repeat after {X,X}) produce no new byte. This is accepted behaviour.
- **Parser FSM:** states IDLE, EXT, BRK, EXT_BRK; reset to IDLE. Transitions on a new byte only.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - 00, AA, E1, EE, FA, FE, FF -> ignored, stay in IDLE.
    - Any other byte -> emit make (ext=0), stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT.
    - Ignored set -> IDLE.
    - Any other byte -> emit make (ext=1) -> IDLE.
  - BRK:
    - E0 -> EXT (resync).
    - F0 -> stay in BRK.
    - Any other byte -> emit break (ext=0) -> IDLE.
  - EXT_BRK:
    - E0/F0 -> stay in EXT_BRK.
    - Any other byte -> emit break (ext=1) -> IDLE.
- **Shift tracking:**
  - A non-extended make of 0x12 or 0x59 sets the matching internal bit; the break clears it.
  - shift_held is the OR of the two bits.
  - The bits update in the same edge the event is emitted.
  - Shift events are queued like any other event.
- **ASCII translation** (non-extended only; extended -> 0x00). Computed at emit time using the shift state *before* this event.
  - Letters, lower case unless shift: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Upper case = lower case − 0x20.
  - Digits, shift-independent: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08. All others -> 0x00.
  - Break events carry the same ASCII as the corresponding make.
- **FIFO:**
  - Entry is 18 bits {ext, break, key, ascii}.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH.
  - Pop when ev_valid && ev_ready.
  - Push on emit.
  - Full and push without pop -> event dropped, overflow <= 1. overflow stays set until reset.
  - Full with simultaneous push and pop -> both occur, no drop.
  - Empty with push -> ev_valid rises next cycle; there is no same-cycle bypass.

## Timing
- Reset values:
  - ev_valid = 0, ev_key = 0x00, ev_ext = 0, ev_break = 0, ev_ascii = 0x00.
  - shift_held = 0, overflow = 0.
  - FSM in IDLE, FIFO empty.
- Latency:
  - code changes after edge N; the FSM and FIFO update on edge N+1.
  - ev_valid is high after edge N+1 if the FIFO was empty.
- Head outputs are registered or driven from the FIFO memory at the read pointer. They are stable while ev_valid && !ev_ready.
- Reset asserted mid-sequence (e.g. in BRK) discards FIFO contents, parser state and shift state immediately.

## Test plan
- Feed 1C -> code {1C,00}, then F0, then 1C, with ev_ready=1.
  - Required: two events, {key=1C, ext=0, break=0, ascii=0x61} then {1C, 0, 1, 0x61}.
  - Required: ev_valid high exactly 1 cycle after each emitting change.
- Shift make (12), then 1C, then F0 12, then 1C.
  - Required: ascii values 0x00, 0x41, 0x00, 0x61.
  - Required: shift_held is 1 between the 12 make and the 12 break.
- E0 75, then E0 F0 75.
  - Required: {75, ext=1, break=0, ascii=0x00} then {75, 1, 1, 0x00}.
- ev_ready=0 and 5 makes (16, 1E, 26, 25, 2E) with FIFO_DEPTH=4.
  - Required: overflow=1 after the 5th.
  - Required: draining yields '1'..'4' in order, then ev_valid=0.
- FIFO full; one make arrives in the same cycle as ev_ready=1.
  - Required: no drop, overflow stays 0, 4 entries remain, the new one is last.
- Feed F0, assert rst_n=0 for 1 cycle, then feed 1C.
  - Required: a make event 1C (not a break), with all outputs at reset values during reset.
